pc_fetch_sequencer: RTL

Parametrised program-counter and fetch sequencer for the RV32/RV64 core front end. It issues instruction-memory fetch requests with a req/ready handshake and handles pipeline stalls. It computes next-PC for sequential, conditional-branch (B-type), JAL and JALR flow using correctly sign-extended immediates. It detects misaligned targets and accepts an external redirect for traps and flushes.

---
 rtl/pc_fetch_sequencer_if.sv | 28 ++
 rtl/pc_fetch_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus for pc_fetch_sequencer: imem handshake, control-flow inputs and PC/fault/count outputs.
interface pc_fetch_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic            imem_ready;
  logic [31:0]     inst_code;
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] rs1_value;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_address;
  logic [XLEN-1:0] inst_address;
  logic [XLEN-1:0] pc_plus4;
  logic            misaligned_fault;
  logic [XLEN-1:0] fault_address;
  logic [XLEN-1:0] instr_count;

  modport master (
    output imem_req, inst_address, pc_plus4, misaligned_fault, fault_address, instr_count,
    input  imem_ready, inst_code, stall, branch_taken, rs1_value, redirect_valid, redirect_address
  );

  modport slave (
    input  imem_req, inst_address, pc_plus4, misaligned_fault, fault_address, instr_count,
    output imem_ready, inst_code, stall, branch_taken, rs1_value, redirect_valid, redirect_address
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter and fetch sequencer: req/ready fetch, stall hold, branch/JAL/JALR next-PC,
// misaligned-target fault and highest-priority redirect.
module pc_fetch_sequencer #(
  parameter int unsigned           XLEN         = 32,
  parameter logic [XLEN-1:0]       RESET_VECTOR = '0,
  parameter bit                    COUNT_EN     = 1'b1
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  pc_fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_FAULT} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_held_inst;
  logic            r_imem_req;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_address;

  logic [31:0]     w_inst;
  logic [6:0]      w_opcode;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_accept;
  logic            w_release;
  logic            w_update;
  logic            w_misaligned;

  // A stalled instruction is decoded from the held copy once the stall lifts.
  assign w_inst     = (r_state == S_HOLD) ? r_held_inst : bus.inst_code;
  assign w_opcode   = w_inst[6:0];
  assign w_pc_plus4 = r_pc + XLEN'(4);

  assign w_imm_b = {{(XLEN-12){w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_j = {{(XLEN-20){w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
  assign w_imm_i = {{(XLEN-12){w_inst[31]}}, w_inst[31:20]};

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (w_opcode)
      7'b1100011: if (bus.branch_taken) w_next_pc = r_pc + w_imm_b;
      7'b1101111: w_next_pc = r_pc + w_imm_j;
      7'b1100111: w_next_pc = (bus.rs1_value + w_imm_i) & ~XLEN'(1);
      default:    w_next_pc = w_pc_plus4;
    endcase
  end

  assign w_redirect_pc = bus.redirect_address & ~XLEN'(3);
  assign w_misaligned  = (w_next_pc[1:0] != 2'b00);
  assign w_accept      = (r_state == S_FETCH) && bus.imem_ready && !bus.stall && !bus.redirect_valid;
  assign w_release     = (r_state == S_HOLD) && !bus.stall && !bus.redirect_valid;
  assign w_update      = w_accept || w_release;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state         <= S_BOOT;
      r_pc            <= RESET_VECTOR;
      r_held_inst     <= '0;
      r_imem_req      <= 1'b0;
      r_fault         <= 1'b0;
      r_fault_address <= '0;
    end else if (bus.redirect_valid) begin
      r_state    <= S_FETCH;
      r_pc       <= w_redirect_pc;
      r_imem_req <= 1'b1;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (bus.imem_ready && bus.stall) begin
            r_held_inst <= bus.inst_code;
            r_state     <= S_HOLD;
            r_imem_req  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!bus.stall) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        default: ;
      endcase
      // A bad target parks the sequencer in FAULT and leaves the PC on the offending instruction.
      if (w_update) begin
        if (w_misaligned) begin
          r_fault         <= 1'b1;
          r_fault_address <= w_next_pc;
          r_state         <= S_FAULT;
          r_imem_req      <= 1'b0;
        end else begin
          r_pc <= w_next_pc;
        end
      end
    end
  end

  generate
    if (COUNT_EN) begin : g_count
      logic [XLEN-1:0] r_instr_count;
      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_instr_count <= '0;
        end else if (w_update) begin
          r_instr_count <= r_instr_count + XLEN'(1);
        end
      end
      assign bus.instr_count = r_instr_count;
    end else begin : g_no_count
      assign bus.instr_count = '0;
    end
  endgenerate

  assign bus.imem_req         = r_imem_req;
  assign bus.inst_address     = r_pc;
  assign bus.pc_plus4         = w_pc_plus4;
  assign bus.misaligned_fault = r_fault;
  assign bus.fault_address    = r_fault_address;

endmodule
